fir_tap_sequencer: RTL and testbench

//  Control FSM for a time-multiplexed FIR low-pass filter: one shared MAC, external delay-line and coefficient RAMs.
//  On each audio_ready_in strobe: write the sample into a circular delay line, then issue NUM_TAPS read-address pairs.

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_tap_sequencer_if.sv | 45 ++++
 rtl/fir_valid_pipe.sv | 38 +++
 rtl/fir_tap_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared state encoding, sample width and 8-bit saturation helper for the FIR tap sequencer.
package fir_pkg;

  localparam int AUDIO_W = 8;
  localparam int SAT_W   = 64;

  localparam logic signed [AUDIO_W-1:0] SAMPLE_MAX = 8'sh7F;
  localparam logic signed [AUDIO_W-1:0] SAMPLE_MIN = 8'sh80;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WRITE,
    RUN,
    DRAIN,
    CAPTURE
  } fir_state_t;

  // Clamp a sign-extended value into the signed 8-bit sample range.
  function automatic logic signed [AUDIO_W-1:0] sat8(input logic signed [SAT_W-1:0] v);
    if (v > 64'sd127) begin
      return SAMPLE_MAX;
    end else if (v < -64'sd128) begin
      return SAMPLE_MIN;
    end else begin
      return v[AUDIO_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Signal bundle between the FIR tap sequencer and its sample source, RAMs, MAC and sink.
// overrun_count_out exists only when FIR_OVERRUN_CNT_EN is defined.
interface fir_tap_sequencer_if #(
  parameter int AW    = 5,
  parameter int ACC_W = 32
);

  logic                              audio_ready_in;
  logic signed [fir_pkg::AUDIO_W-1:0] audio_in;
  logic                              dl_we_out;
  logic [AW-1:0]                     dl_addr_out;
  logic signed [fir_pkg::AUDIO_W-1:0] dl_wdata_out;
  logic [AW-1:0]                     coef_addr_out;
  logic                              mac_clear_out;
  logic                              mac_en_out;
  logic signed [ACC_W-1:0]           mac_acc_in;
  logic signed [fir_pkg::AUDIO_W-1:0] filtered_audio;
  logic                              data_ready_out;
  logic                              busy_out;
  logic                              overrun_out;
`ifdef FIR_OVERRUN_CNT_EN
  logic [15:0]                       overrun_count_out;
`endif

  modport master (
    input  audio_in, audio_ready_in, mac_acc_in,
`ifdef FIR_OVERRUN_CNT_EN
    output overrun_count_out,
`endif
    output dl_we_out, dl_addr_out, dl_wdata_out, coef_addr_out,
    output mac_clear_out, mac_en_out,
    output filtered_audio, data_ready_out, busy_out, overrun_out
  );

  modport slave (
    output audio_in, audio_ready_in, mac_acc_in,
`ifdef FIR_OVERRUN_CNT_EN
    input  overrun_count_out,
`endif
    input  dl_we_out, dl_addr_out, dl_wdata_out, coef_addr_out,
    input  mac_clear_out, mac_en_out,
    input  filtered_audio, data_ready_out, busy_out, overrun_out
  );

endinterface

// File: rtl/fir_valid_pipe.sv
// Fixed-depth shift register that delays {issue_valid, first_tap} to line up with the MAC input.
module fir_valid_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [W-1:0] q_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_in or posedge rst_in) begin
          if (rst_in) begin
            q_reg <= '0;
          end else begin
            q_reg <= din;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk_in or posedge rst_in) begin
          if (rst_in) begin
            q_reg <= '0;
          end else begin
            q_reg <= g_stage[gi-1].q_reg;
          end
        end
      end
    end
  endgenerate

  assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Control FSM for a time-multiplexed FIR: delay-line write, tap address issue, MAC control, saturated capture.
// Define FIR_OVERRUN_CNT_EN to add a saturating 16-bit count of overrun_out pulses (overrun_count_out).
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int NUM_TAPS  = 32,
  parameter int AW        = $clog2(NUM_TAPS),
  parameter int MAC_LAT   = 2,
  parameter int ACC_W     = 32,
  parameter int COEF_FRAC = 15
) (
  input logic                 clk_in,
  input logic                 rst_in,
  fir_tap_sequencer_if.master bus
);

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [AW-1:0] TAP_LAST   = AW'(NUM_TAPS - 1);
  localparam logic [AW:0]   INIT_END   = (AW+1)'(NUM_TAPS);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT - 1);

  fir_state_t                state_reg;
  logic [AW-1:0]             wr_ptr_reg;
  logic [AW-1:0]             base_reg;
  logic [AW-1:0]             tap_reg;
  logic [AW-1:0]             dl_addr_reg;
  logic [AW:0]               init_reg;
  logic [DW-1:0]             drain_reg;
  logic                      pending_valid_reg;
  logic signed [AUDIO_W-1:0] pending_data_reg;
  logic signed [AUDIO_W-1:0] dl_wdata_reg;
  logic signed [AUDIO_W-1:0] filtered_reg;
  logic                      dl_we_reg;
  logic                      data_ready_reg;
  logic                      busy_reg;
  logic                      overrun_reg;

  logic                      strobe;
  logic                      take_direct;
  logic                      consume;
  logic                      go_write;
  logic                      store_pending;
  logic                      drop;
  logic signed [AUDIO_W-1:0] go_sample;
  logic signed [ACC_W-1:0]   acc_shift;
  logic signed [SAT_W-1:0]   acc_wide;
  logic [1:0]                pipe_out;

  // A strobe seen in IDLE with nothing queued starts immediately; everything else goes via pending.
  assign strobe        = bus.audio_ready_in;
  assign take_direct   = (state_reg == IDLE) && !pending_valid_reg && strobe;
  assign consume       = ((state_reg == IDLE) || (state_reg == CAPTURE)) && pending_valid_reg;
  assign go_write      = take_direct || consume;
  assign go_sample     = consume ? pending_data_reg : bus.audio_in;
  assign store_pending = strobe && !take_direct && (!pending_valid_reg || consume);
  assign drop          = strobe && pending_valid_reg && !consume;

  assign acc_shift = bus.mac_acc_in >>> COEF_FRAC;
  assign acc_wide  = {{(SAT_W-ACC_W){acc_shift[ACC_W-1]}}, acc_shift};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg         <= INIT;
      wr_ptr_reg        <= '0;
      base_reg          <= '0;
      tap_reg           <= '0;
      dl_addr_reg       <= '0;
      init_reg          <= '0;
      drain_reg         <= '0;
      pending_valid_reg <= 1'b0;
      pending_data_reg  <= '0;
      dl_wdata_reg      <= '0;
      filtered_reg      <= '0;
      dl_we_reg         <= 1'b0;
      data_ready_reg    <= 1'b0;
      busy_reg          <= 1'b0;
      overrun_reg       <= 1'b0;
    end else begin
      data_ready_reg <= 1'b0;
      overrun_reg    <= drop;

      if (store_pending) begin
        pending_valid_reg <= 1'b1;
        pending_data_reg  <= bus.audio_in;
      end else if (consume) begin
        pending_valid_reg <= 1'b0;
      end

      case (state_reg)
        INIT: begin
          if (init_reg == INIT_END) begin
            state_reg   <= IDLE;
            dl_we_reg   <= 1'b0;
            dl_addr_reg <= '0;
            busy_reg    <= 1'b0;
          end else begin
            dl_we_reg    <= 1'b1;
            dl_addr_reg  <= init_reg[AW-1:0];
            dl_wdata_reg <= '0;
            busy_reg     <= 1'b1;
            init_reg     <= init_reg + 1'b1;
          end
        end
        IDLE: begin
          busy_reg <= 1'b0;
        end
        WRITE: begin
          state_reg    <= RUN;
          dl_we_reg    <= 1'b0;
          dl_wdata_reg <= '0;
          dl_addr_reg  <= base_reg;
          tap_reg      <= '0;
        end
        RUN: begin
          if (tap_reg == TAP_LAST) begin
            state_reg   <= DRAIN;
            drain_reg   <= '0;
            tap_reg     <= '0;
            dl_addr_reg <= '0;
          end else begin
            tap_reg     <= tap_reg + 1'b1;
            // Walk backwards through the circular delay line: newest sample pairs with coef 0.
            dl_addr_reg <= (dl_addr_reg == '0) ? TAP_LAST : dl_addr_reg - 1'b1;
          end
        end
        DRAIN: begin
          if (drain_reg == DRAIN_LAST) begin
            state_reg <= CAPTURE;
          end else begin
            drain_reg <= drain_reg + 1'b1;
          end
        end
        CAPTURE: begin
          filtered_reg   <= sat8(acc_wide);
          data_ready_reg <= 1'b1;
          state_reg      <= IDLE;
          busy_reg       <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase

      // Starting a sample write overrides the IDLE/CAPTURE defaults above.
      if (go_write) begin
        state_reg    <= WRITE;
        dl_we_reg    <= 1'b1;
        dl_addr_reg  <= wr_ptr_reg;
        dl_wdata_reg <= go_sample;
        base_reg     <= wr_ptr_reg;
        wr_ptr_reg   <= (wr_ptr_reg == TAP_LAST) ? '0 : wr_ptr_reg + 1'b1;
        busy_reg     <= 1'b1;
      end
    end
  end

  fir_valid_pipe #(
    .DEPTH (MAC_LAT),
    .W     (2)
  ) u_valid_pipe (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .din    ({state_reg == RUN, (state_reg == RUN) && (tap_reg == '0)}),
    .dout   (pipe_out)
  );

  assign bus.dl_we_out      = dl_we_reg;
  assign bus.dl_addr_out    = dl_addr_reg;
  assign bus.dl_wdata_out   = dl_wdata_reg;
  assign bus.coef_addr_out  = tap_reg;
  assign bus.mac_en_out     = pipe_out[1];
  assign bus.mac_clear_out  = pipe_out[0];
  assign bus.filtered_audio = filtered_reg;
  assign bus.data_ready_out = data_ready_reg;
  assign bus.busy_out       = busy_reg;
  assign bus.overrun_out    = overrun_reg;

`ifdef FIR_OVERRUN_CNT_EN
  logic [15:0] overrun_count_reg;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      overrun_count_reg <= '0;
    end else if (overrun_reg && (overrun_count_reg != 16'hFFFF)) begin
      overrun_count_reg <= overrun_count_reg + 16'd1;
    end
  end

  assign bus.overrun_count_out = overrun_count_reg;
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with a behavioural delay-line RAM, coefficient ROM and MAC.
module tb_fir_tap_sequencer;

  localparam int NUM_TAPS = 32;
  localparam int AW       = 5;
  localparam int ACC_W    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_tap_sequencer_if #(.AW(AW), .ACC_W(ACC_W)) bus ();

  fir_tap_sequencer #(
    .NUM_TAPS  (NUM_TAPS),
    .AW        (AW),
    .MAC_LAT   (2),
    .ACC_W     (ACC_W),
    .COEF_FRAC (15)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  // Environment: one-cycle RAM read, one-cycle multiply, accumulate on mac_en.
  logic signed [7:0]  dl_mem   [NUM_TAPS];
  logic signed [31:0] coef_mem [NUM_TAPS];
  logic signed [31:0] rd_q, cf_q, prod_q, acc_q;

  always @(posedge clk) begin
    if (bus.dl_we_out) dl_mem[bus.dl_addr_out] <= bus.dl_wdata_out;
    rd_q   <= 32'(dl_mem[bus.dl_addr_out]);
    cf_q   <= coef_mem[bus.coef_addr_out];
    prod_q <= rd_q * cf_q;
    if (bus.mac_en_out) acc_q <= (bus.mac_clear_out ? 32'sd0 : acc_q) + prod_q;
  end
  assign bus.mac_acc_in = acc_q;

  int n_checks = 0;
  int n_pass   = 0;
  int rdy_cyc[$];
  int rdy_val[$];
  int ovr_n;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int cyc_at(input int i);
    return (i < rdy_cyc.size()) ? rdy_cyc[i] : -1;
  endfunction

  function automatic int val_at(input int i);
    return (i < rdy_val.size()) ? rdy_val[i] : -999;
  endfunction

  task automatic set_coefs(input bit all_taps);
    for (int i = 0; i < NUM_TAPS; i++) coef_mem[i] = (i == 0 || all_taps) ? 32'sd32767 : 32'sd0;
  endtask

  // Drives up to 3 strobes at given cycle offsets; records ready cycles/values and overrun pulses.
  task automatic burst(input int n, input int offs[3], input int vals[3], input int span);
    rdy_cyc.delete();
    rdy_val.delete();
    ovr_n = 0;
    for (int c = 0; c < span; c++) begin
      bus.audio_ready_in = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (offs[i] == c) begin
          bus.audio_ready_in = 1'b1;
          bus.audio_in       = 8'(vals[i]);
        end
      end
      @(posedge clk); #1;
      if (bus.data_ready_out) begin
        rdy_cyc.push_back(c + 1);
        rdy_val.push_back(int'(bus.filtered_audio));
      end
      if (bus.overrun_out) ovr_n++;
    end
    bus.audio_ready_in = 1'b0;
    $display("txn strobes=%0d ready=%0d first_cycle=%0d first_val=%0d overrun=%0d",
             n, rdy_cyc.size(), cyc_at(0), val_at(0), ovr_n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (NUM_TAPS + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got;
    int we_n;
    int rd_n;
    bus.audio_in       = '0;
    bus.audio_ready_in = 1'b0;
    set_coefs(1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_we",    int'(bus.dl_we_out), 0);
    check("rst_busy",  int'(bus.busy_out), 0);
    check("rst_ready", int'(bus.data_ready_out), 0);
    check("rst_filt",  int'(bus.filtered_audio), 0);
    check("rst_en",    int'(bus.mac_en_out), 0);
    check("rst_ovr",   int'(bus.overrun_out), 0);
    rst = 1'b0;

    // Delay-line clear sweep
    for (int k = 0; k < NUM_TAPS; k++) begin
      @(posedge clk); #1;
      check("init_we",    int'(bus.dl_we_out), 1);
      check("init_addr",  int'(bus.dl_addr_out), k);
      check("init_wdata", int'(bus.dl_wdata_out), 0);
      check("init_busy",  int'(bus.busy_out), 1);
    end
    @(posedge clk); #1;
    check("idle_we",   int'(bus.dl_we_out), 0);
    check("idle_busy", int'(bus.busy_out), 0);

    // Single tap 0x7FFF, sample 64 -> 63 at cycle 37
    burst(1, '{0, 0, 0}, '{64, 0, 0}, 45);
    check("t1_count", rdy_cyc.size(), 1);
    check("t1_lat",   cyc_at(0), 37);
    check("t1_val",   val_at(0), 63);
    check("t1_ovr",   ovr_n, 0);

    // Two strobes 5 cycles apart -> 37 and 73
    burst(2, '{0, 5, 0}, '{10, -20, 0}, 90);
    check("t2_count", rdy_cyc.size(), 2);
    check("t2_lat0",  cyc_at(0), 37);
    check("t2_lat1",  cyc_at(1), 73);
    check("t2_val0",  val_at(0), 9);
    check("t2_val1",  val_at(1), -20);
    check("t2_ovr",   ovr_n, 0);

    // Three strobes in one busy window -> third dropped
    burst(3, '{0, 3, 6}, '{30, 40, 50}, 90);
    check("t3_count", rdy_cyc.size(), 2);
    check("t3_val0",  val_at(0), 29);
    check("t3_val1",  val_at(1), 39);
    check("t3_lat1",  cyc_at(1), 73);
    check("t3_ovr",   ovr_n, 1);
`ifdef FIR_OVERRUN_CNT_EN
    check("t3_ovr_cnt", int'(bus.overrun_count_out), 1);
`endif

    // Saturation high, then wrap on the 33rd write, then saturation low
    do_reset();
    set_coefs(1'b1);
    for (int i = 0; i < NUM_TAPS; i++) burst(1, '{0, 0, 0}, '{127, 0, 0}, 40);
    check("sat_hi_count", rdy_cyc.size(), 1);
    check("sat_hi_val",   val_at(0), 127);

    bus.audio_in       = 8'sh80;
    bus.audio_ready_in = 1'b1;
    @(posedge clk); #1;
    bus.audio_ready_in = 1'b0;
    check("wrap_we",    int'(bus.dl_we_out), 1);
    check("wrap_waddr", int'(bus.dl_addr_out), 0);
    for (int k = 0; k < NUM_TAPS; k++) begin
      @(posedge clk); #1;
      check("wrap_raddr", int'(bus.dl_addr_out), (NUM_TAPS - k) % NUM_TAPS);
      check("wrap_caddr", int'(bus.coef_addr_out), k);
    end
    got = 0;
    for (int n = 0; n < 10 && got == 0; n++) begin
      @(posedge clk); #1;
      got = int'(bus.data_ready_out);
    end
    check("wrap_ready", got, 1);
    $display("txn wrap sample written at addr 0, ready=%0d", got);

    for (int i = 0; i < NUM_TAPS - 1; i++) burst(1, '{0, 0, 0}, '{-128, 0, 0}, 40);
    check("sat_lo_count", rdy_cyc.size(), 1);
    check("sat_lo_val",   val_at(0), -128);

    // Reset mid-RUN with a pending sample queued
    bus.audio_in       = 8'sd5;
    bus.audio_ready_in = 1'b1;
    @(posedge clk); #1;
    bus.audio_ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.audio_in       = 8'sd6;
    bus.audio_ready_in = 1'b1;
    @(posedge clk); #1;
    bus.audio_ready_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_busy", int'(bus.busy_out), 1);
    check("pre_rst_en",   int'(bus.mac_en_out), 1);
    #3 rst = 1'b1;
    #1;
    check("arst_busy",  int'(bus.busy_out), 0);
    check("arst_en",    int'(bus.mac_en_out), 0);
    check("arst_caddr", int'(bus.coef_addr_out), 0);
    check("arst_we",    int'(bus.dl_we_out), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    we_n = 0;
    rd_n = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      we_n += int'(bus.dl_we_out);
      rd_n += int'(bus.data_ready_out);
    end
    $display("txn reset-abort we_cycles=%0d ready_pulses=%0d", we_n, rd_n);
    check("arst_init_we", we_n, NUM_TAPS);
    check("arst_no_ready", rd_n, 0);
    check("arst_idle", int'(bus.busy_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
